// File: rtl/meikyuu_pkg.sv
// meikyuu_pkg -- shared definitions for the button front end.
// Holds the direction indices used to order the button/move/held vectors,
// the per-channel FSM state encoding, the default timing constants for a
// 50 MHz CLOCK_50, and a helper that sizes the repeat timer.
// Auto-repeat is selected at build time by the macro BTN_AUTOREPEAT_EN.
package meikyuu_pkg;

    // Bit positions inside {right, left, down, up} vectors.
    localparam int unsigned UP    = 0;
    localparam int unsigned DOWN  = 1;
    localparam int unsigned LEFT  = 2;
    localparam int unsigned RIGHT = 3;

    // DELAY/REPEAT are used with auto-repeat, HELD without it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HELD   = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_RATE     = 5000000;   // 100 ms

    // Width of a timer that must reach max(a, b) - 1.
    function automatic int timer_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel -- one button: 2-flop synchronizer, debounce, press FSM.
// Ports:
//   CLOCK_50  in  system clock, rising edge
//   reset     in  asynchronous active-high reset
//   btn_i     in  raw asynchronous button, active high
//   pulse_o   out single-cycle move pulse (registered)
//   level_o   out debounced level, aligned with pulse_o
// Macro BTN_AUTOREPEAT_EN: when defined, a held button repeats after
// REPEAT_DELAY cycles and then every REPEAT_RATE cycles; otherwise each
// press yields exactly one pulse and no timer is built.
module btn_channel
    import meikyuu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o,
    output logic level_o
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_err
        $error("btn_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must all be >= 2");
    end

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            held_q;
    logic            pulse_q, pulse_d;
    btn_state_e      state_q, state_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int TMR_W = timer_width(REPEAT_DELAY, REPEAT_RATE);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive
    // disagreement; any agreeing cycle restarts the count.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // level_q can only be high in IDLE right after a debounced rise, so the
    // level itself serves as the press event.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (level_q) begin
                    state_d = DELAY;
                    pulse_d = 1'b1;
                    tmr_d   = '0;
                end
            end
            DELAY: begin
                if (!level_q) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(REPEAT_DELAY - 1)) begin
                    state_d = REPEAT;
                    pulse_d = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            REPEAT: begin
                if (!level_q) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(REPEAT_RATE - 1)) begin
                    pulse_d = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
`else
        case (state_q)
            IDLE: begin
                if (level_q) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                end
            end
            HELD: begin
                if (!level_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            held_q   <= 1'b0;
            pulse_q  <= 1'b0;
            state_q  <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
            tmr_q    <= '0;
`endif
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            held_q   <= level_q;
            pulse_q  <= pulse_d;
            state_q  <= state_d;
`ifdef BTN_AUTOREPEAT_EN
            tmr_q    <= tmr_d;
`endif
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = held_q;

endmodule

// File: rtl/btn_repeat_ctrl.sv
// btn_repeat_ctrl -- four debounced direction buttons with move pulses.
// Ports:
//   CLOCK_50                         in  system clock, rising edge
//   reset                            in  asynchronous active-high reset
//   btn_up/down/left/right           in  raw asynchronous buttons
//   move_up/down/left/right          out single-cycle move-request pulses
//   held[3:0]                        out debounced levels {right,left,down,up}
// Macro BTN_AUTOREPEAT_EN enables hold-to-repeat in every channel.
// A move pulse is masked while the opposing button is held; the masked
// channel keeps its schedule, so releasing the opposite button resumes
// pulses at the next scheduled slot.
module btn_repeat_ctrl
    import meikyuu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic [3:0] held
);

    logic [3:0] btn_vec;
    logic [3:0] pulse_vec;
    logic [3:0] held_vec;

    assign btn_vec = {btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < 4; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .CLOCK_50(CLOCK_50),
            .reset   (reset),
            .btn_i   (btn_vec[g]),
            .pulse_o (pulse_vec[g]),
            .level_o (held_vec[g])
        );
    end

    assign move_up    = pulse_vec[UP]    & ~held_vec[DOWN];
    assign move_down  = pulse_vec[DOWN]  & ~held_vec[UP];
    assign move_left  = pulse_vec[LEFT]  & ~held_vec[RIGHT];
    assign move_right = pulse_vec[RIGHT] & ~held_vec[LEFT];
    assign held       = held_vec;

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
// Bench for btn_repeat_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3. Cycle c is the interval after the c-th clock edge counted
// from the first edge after reset release; inputs for cycle c are applied
// just after that edge and outputs are sampled at the following falling edge.
module tb_btn_repeat_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       move_up, move_down, move_left, move_right;
    logic [3:0] held;

    int checks = 0;
    int errors = 0;
    bit mchk   = 1'b0;

    btn_repeat_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .btn_up    (btn[0]),
        .btn_down  (btn[1]),
        .btn_left  (btn[2]),
        .btn_right (btn[3]),
        .move_up   (move_up),
        .move_down (move_down),
        .move_left (move_left),
        .move_right(move_right),
        .held      (held)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Pulse schedule of a press whose first pulse lands in cycle s.
    function automatic bit sched(input int c, input int s);
        int k;
        k = c - s;
        if (k == 0) return 1'b1;
        if (AUTO && k >= RD && ((k - RD) % RR) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input int c,
                         input logic [3:0] am, input logic [3:0] ah,
                         input logic [3:0] em, input logic [3:0] eh);
        checks++;
        if (am !== em || ah !== eh) begin
            errors++;
            $display("FAIL %s cycle %0d: move=%b held=%b, expected move=%b held=%b",
                     name, c, am, ah, em, eh);
        end
    endtask

    // Reference model: synchronizer and debounce from their rules, pulses
    // from the press start time with plain arithmetic.
    logic [3:0] m_s1, m_s2, m_lvl, m_held;
    int         m_cnt   [4];
    int         m_start [4];
    int         m_cyc;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_s1   <= '0;
            m_s2   <= '0;
            m_lvl  <= '0;
            m_held <= '0;
            m_cyc  <= 0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]   <= 0;
                m_start[i] <= 0;
            end
        end else begin
            m_cyc  <= m_cyc + 1;
            m_s1   <= btn;
            m_s2   <= m_s1;
            m_held <= m_lvl;
            for (int i = 0; i < 4; i++) begin
                if (!m_held[i] && m_lvl[i]) m_start[i] <= m_cyc + 1;
                if (m_s2[i] != m_lvl[i]) begin
                    if (m_cnt[i] == DB - 1) begin
                        m_lvl[i] <= m_s2[i];
                        m_cnt[i] <= 0;
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end else begin
                    m_cnt[i] <= 0;
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (mchk) begin
            logic [3:0] p, em;
            for (int i = 0; i < 4; i++) p[i] = m_held[i] && sched(m_cyc, m_start[i]);
            em[0] = p[0] & ~m_held[1];
            em[1] = p[1] & ~m_held[0];
            em[2] = p[2] & ~m_held[3];
            em[3] = p[3] & ~m_held[2];
            check("model", m_cyc, {move_right, move_left, move_down, move_up}, held, em, m_held);
        end
    end

    typedef struct {
        logic [3:0] btn;
        logic       rst;
        logic [3:0] move;
        logic [3:0] held;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic [3:0] b, input logic r,
                                input logic [3:0] m, input logic [3:0] h);
        vec_t v;
        v.btn  = b;
        v.rst  = r;
        v.move = m;
        v.held = h;
        return v;
    endfunction

    task automatic run_table(input string name);
        btn   = '0;
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(posedge CLOCK_50);
        foreach (tab[c]) begin
            if (c > 0) @(posedge CLOCK_50);
            #1;
            btn   = tab[c].btn;
            reset = tab[c].rst;
            @(negedge CLOCK_50);
            check(name, c, {move_right, move_left, move_down, move_up}, held,
                  tab[c].move, tab[c].held);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = '0;
        @(posedge CLOCK_50);
        #1 mchk = 1'b1;

        // Single held button: first pulse after debounce, then repeats.
        tab.delete();
        for (int c = 0; c < 26; c++)
            tab.push_back(mk(4'b0001, 1'b0, {3'b000, sched(c, 7)},
                             (c >= 7) ? 4'b0001 : 4'b0000));
        run_table("s1_hold_up");

        // Bouncing input never settles long enough to be accepted.
        tab.delete();
        for (int c = 0; c < 40; c++)
            tab.push_back(mk({1'b0, ((c / 2) % 2) == 0, 2'b00}, 1'b0, 4'b0000, 4'b0000));
        run_table("s2_bounce_left");

        // Opposing pair: both masked; after down is released, up resumes
        // on its own schedule.
        tab.delete();
        for (int c = 0; c < 46; c++) begin
            logic h0, h1;
            h0 = (c >= 7);
            h1 = (c >= 7) && (c <= 36);
            tab.push_back(mk((c < 30) ? 4'b0011 : 4'b0001, 1'b0,
                             {2'b00, 1'b0, sched(c, 7) && !h1},
                             {2'b00, h1, h0}));
        end
        run_table("s3_opposing");

        // Reset mid-hold: fresh debounce, first pulse 7 cycles after release.
        tab.delete();
        for (int c = 0; c < 36; c++) begin
            logic hr, pr;
            hr = (c >= 7 && c < 12) || (c >= 20);
            pr = (c < 12 && sched(c, 7)) || (c >= 20 && sched(c, 20));
            tab.push_back(mk(4'b1000, c == 12, {pr, 3'b000}, {hr, 3'b000}));
        end
        run_table("s4_reset_hold");

        // Long hold of down: one pulse without auto-repeat, repeats with it.
        tab.delete();
        for (int c = 0; c < 100; c++)
            tab.push_back(mk(4'b0010, 1'b0, {2'b00, sched(c, 7), 1'b0},
                             (c >= 7) ? 4'b0010 : 4'b0000));
        run_table("s5_hold_down");

        // Non-opposing simultaneous presses pulse together.
        tab.delete();
        for (int c = 0; c < 30; c++) begin
            logic p;
            p = sched(c, 7);
            tab.push_back(mk(4'b1001, 1'b0, {p, 2'b00, p},
                             (c >= 7) ? 4'b1001 : 4'b0000));
        end
        run_table("s6_up_right");

        // Random button activity with occasional resets, model-checked.
        btn = '0;
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(posedge CLOCK_50);
            #1;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            reset = ($urandom_range(0, 249) == 0);
        end

        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        btn = '0;
        @(negedge CLOCK_50);
        mchk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
